// File: rtl/timer_irq_source_if.sv
// Register-bus and interrupt signals between the system bridge and timer_irq_source.
// The bridge drives the master side and the timer implements the slave side.
interface timer_irq_source_if;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    modport master (output Addr, We, DIn, input DOut, IRQ);
    modport slave  (input Addr, We, DIn, output DOut, IRQ);
endinterface

// File: rtl/timer_irq_source.sv
// Programmable down-counting timer driving one HWInt bit, with CTRL/PRESET/COUNT word registers.
// Define TIMER_PRESCALE_EN to add an 8-bit PRESCALE register at Addr=3 that slows counting.
module timer_irq_source #(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    timer_irq_source_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_e;

    state_e             state_q, state_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_q, irq_d;
    logic               tick;
    logic               wr_ctrl, wr_preset;
    logic               unused_din;

    assign wr_ctrl    = bus.We && (bus.Addr == 2'd0);
    assign wr_preset  = bus.We && (bus.Addr == 2'd1);
    assign unused_din = ^bus.DIn;

`ifdef TIMER_PRESCALE_EN
    logic [7:0] prescale_q, prescale_d;
    logic [7:0] psc_q, psc_d;
    logic       wr_prescale;

    assign wr_prescale = bus.We && (bus.Addr == 2'd3);
    assign tick        = (psc_q == prescale_q);
`else
    assign tick = 1'b1;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;

        unique case (state_q)
            S_IDLE: if (en_q) state_d = S_LOAD;
            S_LOAD: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    // PRESET of 0 behaves like 1: both reach zero and fire here.
                    if (count_q > CNT_W'(1)) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        count_d = '0;
                        irq_d   = 1'b1;
                        state_d = S_INT;
                    end
                end
            end
            S_INT: begin
                if (mode_q == 2'b01) begin
                    irq_d   = 1'b0;
                    state_d = en_q ? S_LOAD : S_IDLE;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase

        // Bus writes override the FSM, and either one acknowledges the interrupt.
        if (wr_ctrl) begin
            en_d   = bus.DIn[0];
            mode_d = bus.DIn[2:1];
            im_d   = bus.DIn[3];
            irq_d  = 1'b0;
        end
        if (wr_preset) begin
            preset_d = bus.DIn[CNT_W-1:0];
            irq_d    = 1'b0;
        end
    end

`ifdef TIMER_PRESCALE_EN
    always_comb begin
        prescale_d = wr_prescale ? bus.DIn[7:0] : prescale_q;
        psc_d      = (state_q == S_CNT && en_q && !tick) ? psc_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_q <= 8'd0;
            psc_q      <= 8'd0;
        end else begin
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        bus.DOut = '0;
        case (bus.Addr)
            2'd0:    bus.DOut = {28'd0, im_q, mode_q, en_q};
            2'd1:    bus.DOut = 32'(preset_q);
            2'd2:    bus.DOut = 32'(count_q);
`ifdef TIMER_PRESCALE_EN
            2'd3:    bus.DOut = {24'd0, prescale_q};
`endif
            default: bus.DOut = '0;
        endcase
    end

    assign bus.IRQ = im_q & irq_q;

endmodule
